// File: rtl/int_reg_file.sv
// int_reg_file: physical integer register file with registered read ports, writeback write ports and a
// post-reset clear sequence. Define RF_BYPASS_EN for write-first reads; the default build is read-first.

module int_reg_file_rd_lane #(
    parameter int NUM_WBS  = 4,
    parameter int ADDR_W   = 6,
    parameter int DATA_W   = 32,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             run,
    input  logic [ADDR_W-1:0]                addr,
    input  logic [DATA_W-1:0]                stored,
    input  logic [NUM_WBS-1:0]               wb_we,
    input  logic [NUM_WBS-1:0][ADDR_W-1:0]   wb_addr,
    input  logic [NUM_WBS-1:0][DATA_W-1:0]   wb_data,
    output logic [DATA_W-1:0]                data
);

    logic [DATA_W-1:0] fwd;
    logic [DATA_W-1:0] sel;

`ifdef RF_BYPASS_EN
    // Later ports override earlier ones, matching the order the array itself is written in.
    always_comb begin
        fwd = stored;
        for (int j = 0; j < NUM_WBS; j++) begin
            if (wb_we[j] && (wb_addr[j] == addr)) fwd = wb_data[j];
        end
    end
`else
    assign fwd = stored;

    logic unused_wb;
    assign unused_wb = ^{wb_we, wb_addr, wb_data};
`endif

    assign sel = (ZERO_REG && (addr == '0)) ? '0 : fwd;

    always_ff @(posedge clk) begin
        if (rst || !run) data <= '0;
        else             data <= sel;
    end

endmodule

module int_reg_file #(
    parameter int NUM_READS   = 8,
    parameter int NUM_WBS     = 4,
    parameter int NUM_ENTRIES = 64,
    parameter bit ZERO_REG    = 1'b1,
    localparam int ADDR_W     = $clog2(NUM_ENTRIES),
    localparam int TAG_W      = ADDR_W + 1,
    localparam int DATA_W     = 32
) (
    input  logic                               clk,
    input  logic                               rst,
    output logic                               OUT_ready,
    input  logic [NUM_WBS-1:0]                 IN_wbValid,
    input  logic [NUM_WBS-1:0][TAG_W-1:0]      IN_wbTag,
    input  logic [NUM_WBS-1:0][DATA_W-1:0]     IN_wbResult,
    input  logic [NUM_READS-1:0][ADDR_W-1:0]   IN_readAddr,
    output logic [NUM_READS-1:0][DATA_W-1:0]   OUT_readData
);

    localparam int CLR_CYCLES = NUM_ENTRIES / NUM_WBS;
    localparam int CNT_W      = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;

    typedef enum logic {CLEAR, RUN} state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 run;

    logic [NUM_WBS-1:0]               wb_we;
    logic [NUM_WBS-1:0][ADDR_W-1:0]   wb_addr;
    logic [DATA_W-1:0]                mem [NUM_ENTRIES];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == CLEAR) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(CLR_CYCLES - 1)) state_d = RUN;
        end
    end

    assign run       = (state_q == RUN);
    assign OUT_ready = run;

    // Tag bit ADDR_W marks a result with no destination register.
    always_comb begin
        for (int j = 0; j < NUM_WBS; j++) begin
            wb_addr[j] = IN_wbTag[j][ADDR_W-1:0];
            wb_we[j]   = run && !rst && IN_wbValid[j] && !IN_wbTag[j][ADDR_W] &&
                         !(ZERO_REG && (wb_addr[j] == '0));
        end
    end

    // Storage has no reset of its own; the clear sequence zeroes NUM_WBS entries per cycle.
    always_ff @(posedge clk) begin
        if (!run) begin
            for (int k = 0; k < NUM_WBS; k++) begin
                mem[ADDR_W'(int'(cnt_q) * NUM_WBS + k)] <= '0;
            end
        end else begin
            for (int j = 0; j < NUM_WBS; j++) begin
                if (wb_we[j]) mem[wb_addr[j]] <= IN_wbResult[j];
            end
        end
    end

    for (genvar i = 0; i < NUM_READS; i++) begin : g_rd
        int_reg_file_rd_lane #(
            .NUM_WBS  (NUM_WBS),
            .ADDR_W   (ADDR_W),
            .DATA_W   (DATA_W),
            .ZERO_REG (ZERO_REG)
        ) u_lane (
            .clk     (clk),
            .rst     (rst),
            .run     (run),
            .addr    (IN_readAddr[i]),
            .stored  (mem[IN_readAddr[i]]),
            .wb_we   (wb_we),
            .wb_addr (wb_addr),
            .wb_data (IN_wbResult),
            .data    (OUT_readData[i])
        );
    end

endmodule

// File: tb/tb_int_reg_file.sv
// tb_int_reg_file: directed vectors for int_reg_file (default parameters) plus reset/clear sequences.

module tb_int_reg_file;

`ifdef RF_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              ready;
    logic [3:0]        wbv;
    logic [3:0][6:0]   wbt;
    logic [3:0][31:0]  wbd;
    logic [7:0][5:0]   ra;
    logic [7:0][31:0]  rd;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    int_reg_file dut (
        .clk          (clk),
        .rst          (rst),
        .OUT_ready    (ready),
        .IN_wbValid   (wbv),
        .IN_wbTag     (wbt),
        .IN_wbResult  (wbd),
        .IN_readAddr  (ra),
        .OUT_readData (rd)
    );

    typedef struct {
        string            nm;
        logic [3:0]       wv;
        logic [3:0][6:0]  wt;
        logic [3:0][31:0] wd;
        logic [7:0][5:0]  ra;
        logic [7:0][31:0] ex;
    } vec_t;

    vec_t vt[$];
    vec_t v;

    function automatic vec_t mkv(input string nm, input logic [3:0] wv, input logic [3:0][6:0] wt,
                                 input logic [3:0][31:0] wd, input logic [5:0] a, input logic [31:0] e);
        vec_t r;
        r.nm = nm; r.wv = wv; r.wt = wt; r.wd = wd;
        r.ra = {8{a}};
        r.ex = {8{e}};
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] or_all();
        logic [31:0] x = '0;
        for (int p = 0; p < 8; p++) x |= rd[p];
        return x;
    endfunction

    // One reset cycle, then 16 clear cycles with ready low and reads zero, then ready high.
    task automatic do_reset(input bit wb_during, input string tag);
        rst = 1'b1; wbv = '0; ra = {8{6'd5}};
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        if (wb_during) begin
            wbv = 4'b0001; wbt[0] = 7'h0B; wbd[0] = 32'h77;
        end
        for (int c = 0; c < 16; c++) begin
            chk($sformatf("%s_ready_c%0d", tag, c), 32'(ready), 32'd0);
            chk($sformatf("%s_data_c%0d", tag, c), or_all(), 32'd0);
            @(negedge clk);
        end
        wbv = '0;
        chk($sformatf("%s_ready_up", tag), 32'(ready), 32'd1);
        chk($sformatf("%s_data_up", tag), or_all(), 32'd0);
    endtask

    initial begin
        rst = 1'b1; wbv = '0; wbt = '0; wbd = '0; ra = '0;
        do_reset(1'b0, "rst0");

        vt.push_back(mkv("wr5_same", 4'b0001, {7'h00, 7'h00, 7'h00, 7'h05},
                         {32'h0, 32'h0, 32'h0, 32'hDEADBEEF}, 6'd5, BYP ? 32'hDEADBEEF : 32'h0));
        vt.push_back(mkv("rd5", 4'b0000, '0, '0, 6'd5, 32'hDEADBEEF));
        vt.push_back(mkv("wr10_same", 4'b0010, {7'h00, 7'h00, 7'h0A, 7'h00},
                         {32'h0, 32'h0, 32'h1234, 32'h0}, 6'd10, BYP ? 32'h1234 : 32'h0));
        vt.push_back(mkv("rd10", 4'b0000, '0, '0, 6'd10, 32'h1234));
        vt.push_back(mkv("wr7_dup", 4'b1001, {7'h07, 7'h00, 7'h00, 7'h07},
                         {32'h3, 32'h0, 32'h0, 32'h1}, 6'd7, BYP ? 32'h3 : 32'h0));
        vt.push_back(mkv("wr7_notag", 4'b0100, {7'h00, 7'h47, 7'h00, 7'h00},
                         {32'h0, 32'hBAD, 32'h0, 32'h0}, 6'd7, 32'h3));
        vt.push_back(mkv("rd7", 4'b0000, '0, '0, 6'd7, 32'h3));
        vt.push_back(mkv("wr0_same", 4'b0010, {7'h00, 7'h00, 7'h00, 7'h00},
                         {32'h0, 32'h0, 32'hFFFFFFFF, 32'h0}, 6'd0, 32'h0));
        vt.push_back(mkv("rd0", 4'b0000, '0, '0, 6'd0, 32'h0));
        vt.push_back(mkv("wr12_inval", 4'b0000, {7'h00, 7'h0C, 7'h00, 7'h00},
                         {32'h0, 32'hCAFE, 32'h0, 32'h0}, 6'd12, 32'h0));
        vt.push_back(mkv("rd12", 4'b0000, '0, '0, 6'd12, 32'h0));

        v = mkv("wr_mixed", 4'b1111, {7'h3F, 7'h22, 7'h21, 7'h20},
                {32'hFFFF0000, 32'hA2, 32'hA1, 32'hA0}, 6'd0, 32'h0);
        v.ra = {6'h00, 6'h07, 6'h0A, 6'h05, 6'h3F, 6'h22, 6'h21, 6'h20};
        v.ex = {32'h0, 32'h3, 32'h1234, 32'hDEADBEEF, 32'h0, 32'h0, 32'h0, 32'h0};
        if (BYP) v.ex[3:0] = {32'hFFFF0000, 32'hA2, 32'hA1, 32'hA0};
        vt.push_back(v);

        v = mkv("rd_mixed", 4'b0000, '0, '0, 6'd0, 32'h0);
        v.ra = {6'h00, 6'h07, 6'h0A, 6'h05, 6'h3F, 6'h22, 6'h21, 6'h20};
        v.ex = {32'h0, 32'h3, 32'h1234, 32'hDEADBEEF, 32'hFFFF0000, 32'hA2, 32'hA1, 32'hA0};
        vt.push_back(v);

        foreach (vt[k]) begin
            wbv = vt[k].wv; wbt = vt[k].wt; wbd = vt[k].wd; ra = vt[k].ra;
            @(negedge clk);
            for (int p = 0; p < 8; p++) chk($sformatf("%s[%0d]", vt[k].nm, p), rd[p], vt[k].ex[p]);
        end
        wbv = '0;

        // Mid-run reset: entry 9 must come back as zero, and a write during clear is dropped.
        wbv = 4'b0001; wbt[0] = 7'h09; wbd[0] = 32'h55; ra = {8{6'd9}};
        @(negedge clk);
        wbv = '0;
        @(negedge clk);
        for (int p = 0; p < 8; p++) chk($sformatf("rd9_pre[%0d]", p), rd[p], 32'h55);

        do_reset(1'b1, "rst1");
        ra = {6'h20, 6'h05, 6'h0B, 6'h09, 6'h20, 6'h05, 6'h0B, 6'h09};
        @(negedge clk);
        for (int p = 0; p < 8; p++) chk($sformatf("rd_post_clear[%0d]", p), rd[p], 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
